fp_class_pipe: RTL

- Pipelined, elastic RISC-V FCLASS unit for the FPU.
- Parametrised in operand width; supports single and double formats with NaN-boxing checks.
- Classifies one operand per cycle into the 10-bit one-hot FCLASS mask, zero-extended to XLEN.
- Uses valid/ready handshakes on both sides and carries a destination tag; sits between FPU issue and the integer writeback arbiter.

---
 rtl/fp_class_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fp_class_pipe.sv
// fp_class_pipe: two-stage elastic RISC-V FCLASS unit.
//   S1 decodes sign and a one-hot class {zero, sub, norm, inf, snan, qnan};
//   S2 expands that into the 10-bit FCLASS mask, which drives the outputs.
// Ports:
//   clk, rst (async, active-high), flush (sync kill of in-flight ops)
//   in_valid/in_ready, in_fmt (0 single, 1 double), in_op[FLEN], in_tag[TAG_W]
//   out_valid/out_ready, out_result[XLEN] (mask zero-extended), out_tag[TAG_W]
module fp_class_pipe #(
    parameter int XLEN  = 32,
    parameter int FLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_fmt,
    input  logic [FLEN-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int C_ZERO = 0;
    localparam int C_SUB  = 1;
    localparam int C_NORM = 2;
    localparam int C_INF  = 3;
    localparam int C_SNAN = 4;
    localparam int C_QNAN = 5;

    // Per-format field flags
    logic s_sign, s_exp_zero, s_exp_ones, s_man_zero, s_man_msb;
    logic d_sign, d_exp_zero, d_exp_ones, d_man_zero, d_man_msb;
    logic is_dbl, boxed;

    assign s_sign     = in_op[31];
    assign s_exp_zero = (in_op[30:23] == '0);
    assign s_exp_ones = &in_op[30:23];
    assign s_man_zero = (in_op[22:0] == '0);
    assign s_man_msb  = in_op[22];

    generate
        if (FLEN == 64) begin : g_dbl
            assign is_dbl     = in_fmt;
            // A single held in a 64-bit register must have an all-ones upper word.
            assign boxed      = in_fmt | (&in_op[FLEN-1:32]);
            assign d_sign     = in_op[63];
            assign d_exp_zero = (in_op[62:52] == '0);
            assign d_exp_ones = &in_op[62:52];
            assign d_man_zero = (in_op[51:0] == '0);
            assign d_man_msb  = in_op[51];
        end else begin : g_sgl
            assign is_dbl     = 1'b0;
            assign boxed      = 1'b1;
            assign d_sign     = 1'b0;
            assign d_exp_zero = 1'b0;
            assign d_exp_ones = 1'b0;
            assign d_man_zero = 1'b0;
            assign d_man_msb  = 1'b0;
        end
    endgenerate

    // Pipeline state
    logic             v1_q, v1_d, v2_q, v2_d;
    logic             sign_q, sign_d;
    logic [5:0]       cls_q, cls_d;
    logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
    logic [9:0]       mask_q, mask_d;

    logic rdy1, rdy2, in_hs, xfer, out_hs;
    logic exp_zero, exp_ones, man_zero, man_msb;

    assign rdy2     = !v2_q | out_ready;
    assign rdy1     = !v1_q | rdy2;
    assign in_ready = rdy1 & !rst;
    assign in_hs    = in_valid & in_ready;
    assign xfer     = v1_q & rdy2;
    assign out_hs   = v2_q & out_ready;

    // S1: classify
    always_comb begin
        exp_zero = is_dbl ? d_exp_zero : s_exp_zero;
        exp_ones = is_dbl ? d_exp_ones : s_exp_ones;
        man_zero = is_dbl ? d_man_zero : s_man_zero;
        man_msb  = is_dbl ? d_man_msb  : s_man_msb;

        cls_d = '0;
        if (!boxed)       cls_d[C_QNAN] = 1'b1;
        else if (exp_zero) cls_d[man_zero ? C_ZERO : C_SUB] = 1'b1;
        else if (exp_ones) begin
            if (man_zero)     cls_d[C_INF]  = 1'b1;
            else if (man_msb) cls_d[C_QNAN] = 1'b1;
            else              cls_d[C_SNAN] = 1'b1;
        end else           cls_d[C_NORM] = 1'b1;

        sign_d = is_dbl ? d_sign : s_sign;
        tag1_d = in_tag;
        // Unloaded stages hold their data.
        if (!(in_hs && !flush)) begin
            cls_d  = cls_q;
            sign_d = sign_q;
            tag1_d = tag1_q;
        end
    end

    // S2: expand class into the FCLASS mask
    always_comb begin
        mask_d = '0;
        if (cls_q[C_QNAN])      mask_d[9] = 1'b1;
        else if (cls_q[C_SNAN]) mask_d[8] = 1'b1;
        else if (cls_q[C_INF])  mask_d[sign_q ? 0 : 7] = 1'b1;
        else if (cls_q[C_NORM]) mask_d[sign_q ? 1 : 6] = 1'b1;
        else if (cls_q[C_SUB])  mask_d[sign_q ? 2 : 5] = 1'b1;
        else if (cls_q[C_ZERO]) mask_d[sign_q ? 3 : 4] = 1'b1;
        tag2_d = tag1_q;
        if (!(xfer && !flush)) begin
            mask_d = mask_q;
            tag2_d = tag2_q;
        end
    end

    // Valid bits; flush wins over any handshake in the same cycle.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (in_hs)       v1_d = 1'b1;
        else if (xfer)   v1_d = 1'b0;
        if (xfer)        v2_d = 1'b1;
        else if (out_hs) v2_d = 1'b0;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            sign_q <= 1'b0;
            cls_q  <= '0;
            tag1_q <= '0;
            mask_q <= '0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            sign_q <= sign_d;
            cls_q  <= cls_d;
            tag1_q <= tag1_d;
            mask_q <= mask_d;
            tag2_q <= tag2_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_result = XLEN'(mask_q);
    assign out_tag    = tag2_q;
endmodule
